// File: rtl/sfifo_ctrl.sv
// Single-clock synchronous FIFO with watermarks, FWFT/registered read and synchronous flush.
// Optional sticky overflow/underflow flags are built only when SFIFO_ERR_EN is defined.
module sfifo_ctrl #(
  parameter int unsigned AW        = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned FWFT      = 1,
  parameter int unsigned AFULL_TH  = (1 << AW) - 1,
  parameter int unsigned AEMPTY_TH = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic          re,
  input  logic          flush,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [AW:0]   cnt,
  output logic          ovf,
  output logic          udf,
  input  logic          err_clr
);

  localparam int unsigned Depth    = 1 << AW;
  localparam logic [AW:0] DepthC   = (AW + 1)'(Depth);
  localparam logic [AW:0] AfullTh  = (AW + 1)'(AFULL_TH);
  localparam logic [AW:0] AemptyTh = (AW + 1)'(AEMPTY_TH);
  localparam logic [AW:0] PtrOne   = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] mem [Depth];

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
  logic        full_q, empty_q, afull_q, aempty_q;
  logic        full_d, empty_d, afull_d, aempty_d;
  logic        wt, rd;
  logic [AW-1:0] raddr;

  assign wt    = we & ~full_q;
  assign rd    = re & ~empty_q;
  assign raddr = rptr_q[AW-1:0];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wt) wptr_d = wptr_q + PtrOne;
      if (rd) rptr_d = rptr_q + PtrOne;
      unique case ({wt, rd})
        2'b10:   cnt_d = cnt_q + PtrOne;
        2'b01:   cnt_d = cnt_q - PtrOne;
        default: cnt_d = cnt_q;
      endcase
    end
    // Flags come from the next count so they move on the same edge as cnt.
    full_d   = (cnt_d == DepthC);
    empty_d  = (cnt_d == '0);
    afull_d  = (cnt_d >= AfullTh);
    aempty_d = (cnt_d <= AemptyTh);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wt && !flush) mem[wptr_q[AW-1:0]] <= d;
  end

  if (FWFT != 0) begin : g_fwft
    // Driven to zero while empty so q reads 0 out of reset.
    assign q = empty_q ? '0 : mem[raddr];
  end else begin : g_reg
    logic [DW-1:0] q_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          q_q <= '0;
      else if (rd && !flush) q_q <= mem[raddr];
    end
    assign q = q_q;
  end

  assign full   = full_q;
  assign empty  = empty_q;
  assign afull  = afull_q;
  assign aempty = aempty_q;
  assign cnt    = cnt_q;

`ifdef SFIFO_ERR_EN
  logic ovf_q, udf_q;
  // Setting wins over err_clr in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (we && full_q && !flush) ovf_q <= 1'b1;
      else if (err_clr)           ovf_q <= 1'b0;
      if (re && empty_q && !flush) udf_q <= 1'b1;
      else if (err_clr)            udf_q <= 1'b0;
    end
  end
  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_sfifo_ctrl.sv
// Bench for sfifo_ctrl: an FWFT and a registered-read instance share stimulus and are
// checked against a queue-based reference model.
module tb_sfifo_ctrl;

`ifdef SFIFO_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif
  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       we, re, flush, err_clr;
  logic [7:0] d;
  logic [7:0] q1, q0;
  logic       full1, empty1, afull1, aempty1, ovf1, udf1;
  logic       full0, empty0, afull0, aempty0, ovf0, udf0;
  logic [2:0] cnt1, cnt0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mq[$];
  logic [7:0] q0_m;
  bit         ovf_m, udf_m;

  always #5 clk = ~clk;

  sfifo_ctrl #(.AW(2), .DW(8), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .we(we), .re(re), .flush(flush), .d(d), .q(q1),
    .full(full1), .empty(empty1), .afull(afull1), .aempty(aempty1), .cnt(cnt1),
    .ovf(ovf1), .udf(udf1), .err_clr(err_clr)
  );

  sfifo_ctrl #(.AW(2), .DW(8), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) u_reg (
    .clk(clk), .reset_n(reset_n), .we(we), .re(re), .flush(flush), .d(d), .q(q0),
    .full(full0), .empty(empty0), .afull(afull0), .aempty(aempty0), .cnt(cnt0),
    .ovf(ovf0), .udf(udf0), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq.size();
    check("cnt", cnt1, n);
    check("cnt_reg", cnt0, n);
    check("full", full1, n == Depth);
    check("empty", empty1, n == 0);
    check("afull", afull1, n >= 3);
    check("aempty", aempty1, n <= 1);
    check("full_reg", full0, n == Depth);
    check("empty_reg", empty0, n == 0);
    if (n > 0) check("q_fwft", q1, mq[0]);
    check("q_reg", q0, q0_m);
    check("ovf", ovf1, ovf_m);
    check("udf", udf1, udf_m);
  endtask

  // One clock: drive inputs, advance the model with the pre-edge occupancy, compare.
  task automatic step(input logic w, input logic r, input logic f, input logic c,
                      input logic [7:0] din);
    bit was_full, was_empty;
    we = w; re = r; flush = f; err_clr = c; d = din;
    was_full  = (mq.size() == Depth);
    was_empty = (mq.size() == 0);
    @(posedge clk);
    #1;
    if (ErrEn) begin
      if (w && was_full && !f) ovf_m = 1'b1;
      else if (c)              ovf_m = 1'b0;
      if (r && was_empty && !f) udf_m = 1'b1;
      else if (c)               udf_m = 1'b0;
    end
    if (f) begin
      mq.delete();
    end else begin
      if (r && !was_empty) q0_m = mq.pop_front();
      if (w && !was_full) mq.push_back(din);
    end
    we = 1'b0; re = 1'b0; flush = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    we = 1'b0; re = 1'b0; flush = 1'b0; err_clr = 1'b0;
    mq.delete();
    q0_m = '0; ovf_m = 1'b0; udf_m = 1'b0;
    #1;
    check_all();
    check("rst_q_fwft", q1, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    we = 1'b0; re = 1'b0; flush = 1'b0; err_clr = 1'b0; d = '0;
    q0_m = '0;
    do_reset();

    // Fill to full, watch afull at 3, then a dropped fifth write.
    step(1, 0, 0, 0, 8'h11);
    step(1, 0, 0, 0, 8'h22);
    step(1, 0, 0, 0, 8'h33);
    check("t1_afull_at3", afull1, 1);
    check("t1_notfull_at3", full1, 0);
    step(1, 0, 0, 0, 8'h44);
    check("t1_full", full1, 1);
    step(1, 0, 0, 0, 8'h55);
    check("t1_cnt_after_drop", cnt1, 4);
    // Full with we&re: only the read goes through.
    step(1, 1, 0, 0, 8'h66);
    check("t3_cnt_4to3", cnt1, 3);
    check("t3_q_reg_11", q0, 8'h11);
    step(0, 1, 0, 0, 8'h00);
    check("t1_q_reg_22", q0, 8'h22);
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    check("t1_q_reg_44", q0, 8'h44);
    check("t1_empty", empty1, 1);
    step(0, 1, 0, 0, 8'h00);

    // Empty with we&re: only the write goes through, visible at once in FWFT.
    step(1, 1, 0, 0, 8'hA5);
    check("t3_cnt_0to1", cnt1, 1);
    check("t3_fwft_q", q1, 8'hA5);
    step(0, 1, 0, 0, 8'h00);
    check("t2_q_reg_a5", q0, 8'hA5);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    check("t2_q_reg_hold", q0, 8'hA5);

    // Flush at cnt=3 with we=re=1.
    step(1, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 8'h02);
    step(1, 0, 0, 0, 8'h03);
    step(1, 1, 1, 0, 8'h04);
    check("t5_flush_cnt", cnt1, 0);
    check("t5_flush_q_reg_hold", q0, 8'hA5);
    step(1, 0, 0, 0, 8'h5C);
    check("t5_fwft_after_flush", q1, 8'h5C);
    step(0, 1, 0, 0, 8'h00);
    check("t5_reg_after_flush", q0, 8'h5C);

    // Error flags: overflow, underflow, then clear; set wins over clear.
    for (int i = 0; i < Depth; i++) step(1, 0, 0, 0, 8'(8'hC0 + i));
    step(1, 0, 0, 0, 8'hEE);
    step(0, 0, 0, 0, 8'h00);
    check("t6_ovf_sticky", ovf1, ErrEn);
    for (int i = 0; i < Depth; i++) step(0, 1, 0, 0, 8'h00);
    step(0, 1, 0, 0, 8'h00);
    check("t6_udf", udf1, ErrEn);
    step(0, 1, 0, 1, 8'h00);
    check("t6_set_over_clr", udf1, ErrEn);
    step(0, 0, 0, 1, 8'h00);
    check("t6_clr_ovf", ovf1, 0);

    // Randomised streaming with gaps, covering several pointer wraps.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, 8'($urandom));
      if (i == 200) begin
        step(1, 0, 0, 0, 8'h77);
        do_reset();
      end
    end

    // Reset mid-stream with data held.
    step(1, 0, 0, 0, 8'h99);
    step(1, 1, 0, 0, 8'h9A);
    do_reset();
    check("t6_rst_q_reg", q0, 0);
    step(1, 0, 0, 0, 8'h3C);
    check("rst_then_write", q1, 8'h3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
